axis_frame_capture: RTL and testbench
=====================================

Name: axis_frame_capture

Overview:
- Parametrised AXIS sink that captures complex samples into internal RAM. It is the generalised successor of the fixed-depth capture VIP at the OSPFB output.
- Adds frame-aligned triggering, frame skipping and tlast framing checks.
- Provides a registered read-back port and sticky status, so benches and on-chip debug can snapshot an exact frame window of OSPFB/FFT output.

Parameters:
- WIDTH, 16, bits per real/imag component; tdata is 2*WIDTH (imag in upper half, real in lower half).
- DEPTH, 64, number of samples captured per arm (power of 2, >=2).
- FRAME_LEN, 2048, expected beats per frame (FFT_LEN); >=2.
- SKIP_WID, 8, width of the skip-frame count.
- ERR_WID, 16, width of the saturating error counters.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- arm  in  1  single-cycle pulse; starts or restarts a capture.
- align  in  1  0 = start on the first beat after arm; 1 = start on the first beat after a tlast. Sampled on arm.
- skip_frames  in  SKIP_WID  frames discarded after alignment before capture begins. Sampled on arm.
- s_axis_tdata  in  2*WIDTH  sample.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  frame end.
- s_axis_tready  out  1  sink ready.
- capturing  out  1  high while in the CAPTURE state.
- full  out  1  DEPTH samples stored; sticky.
- wr_count  out  $clog2(DEPTH+1)  samples stored since arm.
- rd_addr  in  $clog2(DEPTH)  read-back address.
- rd_data  out  2*WIDTH  RAM[rd_addr], registered.
- tlast_missing  out  ERR_WID  count of beats at frame position FRAME_LEN-1 without tlast.
- tlast_unexpected  out  ERR_WID  count of beats with tlast at any position other than FRAME_LEN-1.

Behaviour:
- Reset (rst_n=0 at a clk edge), all outputs: tready=0, capturing=0, full=0, wr_count=0, rd_data=0, both error counters=0, position counter=0, state=IDLE. The RAM is not cleared.
- tready: 1 in every state from the first cycle after reset release. The block never back-pressures. A beat = tvalid&tready.
- Frame position counter `pos` (0..FRAME_LEN-1) is maintained in all states:
  - each beat increments `pos`;
  - a beat with tlast, or a beat at pos==FRAME_LEN-1, sets the next pos to 0.
- Framing checks (evaluated on every beat, in every state):
  - pos==FRAME_LEN-1 && !tlast -> tlast_missing++;
  - pos!=FRAME_LEN-1 && tlast -> tlast_unexpected++ (resynchronises pos to 0).
  - Counters saturate at all-ones. Only reset clears them; arm does not.
- States:
  - IDLE: wait for arm. On arm: wr_count<=0, full<=0, latch align and skip_frames into skip_cnt. Next state is CAPTURE if align=0 and skip=0, otherwise ARMED.
  - ARMED: each tlast beat marks a frame boundary.
    - align=0: the first beat after arm counts as the boundary event, so skipping starts immediately.
    - If skip_cnt==0 at a boundary -> CAPTURE, with the first captured beat being the next beat.
    - Otherwise decrement skip_cnt on each boundary.
  - CAPTURE: each beat writes tdata to RAM[wr_count] and increments wr_count. capturing=1.
    - When the write with wr_count==DEPTH-1 occurs -> FULL. wr_count becomes DEPTH, and full=1 the following cycle.
  - FULL: beats are ignored (no RAM write); full and wr_count hold. arm -> behaves as from IDLE.
- align=0 with skip=0: the beat coinciding with the arm cycle is not captured; capture starts with the next beat.
- arm in any non-IDLE state aborts and restarts exactly as from IDLE. Samples already written are left in RAM but are considered invalid.
- arm coinciding with a beat: the beat updates pos and the error counters only; it is not captured.
- Read port: rd_data <= RAM[rd_addr] every cycle (1-cycle latency).
  - A read of an address being written in the same cycle returns the old data.
- Reset mid-capture: on the next edge the block is in IDLE with all outputs at reset values; a new arm is needed.
- No idle-beat gaps are required; tvalid may toggle arbitrarily.

Test Plan:
- Reset 4 cycles, then a counter source (tdata=n, tlast every 2048 beats), align=0, skip=0, arm at beat 10 -> RAM[0..63]=11..74; full rises the cycle after beat 74; wr_count=64; both error counters=0.
- align=1, skip=2, arm at beat 100 -> capture begins at beat 2048*3=6144; RAM[i]=6144+i; capturing is high for exactly 64 beats.
- Random tvalid gaps (50% duty), align=1, skip=0 -> RAM contents are identical to the gapless run; full is asserted after exactly 64 beats.
- Inject tlast at pos 1000, and drop tlast at pos 2047 of the following frame -> tlast_unexpected=1, tlast_missing=1, and pos realigns after the early tlast.
- Re-arm while capturing at wr_count=30 -> wr_count returns to 0, full=0, and capture restarts from the next beat; rst_n low mid-capture -> all outputs at reset values next cycle.
- Read back with rd_addr swept 0..63 after full -> rd_data equals the expected value one cycle after each address; continued input beats do not alter RAM.

Source files
------------

// File: rtl/axis_frame_capture_if.sv
// AXI4-Stream beat bundle for the frame capture sink.
// tdata carries one complex sample: imag in the upper half, real in the lower half.
interface axis_frame_capture_if #(
   parameter int WIDTH = 16
);
   logic [2*WIDTH-1:0] tdata;
   logic               tvalid;
   logic               tlast;
   logic               tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// AXIS sink capturing a DEPTH-sample window of complex samples into RAM.
// The window can be aligned to frame boundaries (tlast) and delayed by a
// number of whole frames. Framing is checked continuously against FRAME_LEN
// with saturating error counters. RAM contents are read back through a
// registered port with one cycle of latency.
module axis_frame_capture #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 64,
   parameter int FRAME_LEN = 2048,
   parameter int SKIP_WID  = 8,
   parameter int ERR_WID   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arm,
   input  logic                       align,
   input  logic [SKIP_WID-1:0]        skip_frames,
   axis_frame_capture_if.slave        s_axis,
   output logic                       capturing,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] wr_count,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [2*WIDTH-1:0]         rd_data,
   output logic [ERR_WID-1:0]         tlast_missing,
   output logic [ERR_WID-1:0]         tlast_unexpected
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(FRAME_LEN);

   localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] WR_LAST  = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_FULL
   } state_t;

   state_t              state_q, state_d;
   logic                tready_q;
   logic [PW-1:0]       pos_q;
   logic [ERR_WID-1:0]  missing_q;
   logic [ERR_WID-1:0]  unexpected_q;
   logic [CW-1:0]       wr_count_q;
   logic                full_q;
   logic                align_q;
   logic [SKIP_WID-1:0] skip_cnt_q;
   logic                first_pend_q;
   logic [2*WIDTH-1:0]  rd_data_q;
   logic [2*WIDTH-1:0]  mem [DEPTH];

   logic                beat;
   logic                pos_at_last;
   logic                boundary;
   logic                arm_load;
   logic                skip_dec;
   logic                wr_en;

   assign beat        = s_axis.tvalid & tready_q;
   assign pos_at_last = (pos_q == POS_LAST);
   // With align=0 the first beat after arm stands in for a frame boundary,
   // so frame skipping starts counting immediately.
   assign boundary    = beat & (s_axis.tlast | (first_pend_q & ~align_q));

   // Ready comes up one cycle after reset release and never drops again.
   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) tready_q <= 1'b0;
      else        tready_q <= 1'b1;
   end

   // Capture FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath controls; arm overrides every state.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      arm_load = 1'b0;
      skip_dec = 1'b0;
      wr_en    = 1'b0;
      if (arm) begin
         arm_load = 1'b1;
         state_d  = (!align && skip_frames == '0) ? S_CAPTURE : S_ARMED;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_ARMED: begin
               if (boundary) begin
                  if (skip_cnt_q == '0) state_d  = S_CAPTURE;
                  else                  skip_dec = 1'b1;
               end
            end
            S_CAPTURE: begin
               if (beat) begin
                  wr_en = 1'b1;
                  if (wr_count_q == WR_LAST) state_d = S_FULL;
               end
            end
            S_FULL: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Frame position tracking and saturating framing-error counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q        <= '0;
         missing_q    <= '0;
         unexpected_q <= '0;
      end else if (beat) begin
         if (pos_at_last && !s_axis.tlast && missing_q != '1)
            missing_q <= missing_q + 1'b1;
         if (!pos_at_last && s_axis.tlast && unexpected_q != '1)
            unexpected_q <= unexpected_q + 1'b1;
         // An early tlast resynchronises the frame position.
         pos_q <= (s_axis.tlast || pos_at_last) ? '0 : pos_q + 1'b1;
      end
   end

   // Arm-time configuration, skip countdown and write pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_count_q   <= '0;
         full_q       <= 1'b0;
         align_q      <= 1'b0;
         skip_cnt_q   <= '0;
         first_pend_q <= 1'b0;
      end else if (arm_load) begin
         wr_count_q   <= '0;
         full_q       <= 1'b0;
         align_q      <= align;
         skip_cnt_q   <= skip_frames;
         first_pend_q <= 1'b1;
      end else begin
         if (beat)     first_pend_q <= 1'b0;
         if (skip_dec) skip_cnt_q   <= skip_cnt_q - 1'b1;
         if (wr_en) begin
            wr_count_q <= wr_count_q + 1'b1;
            if (wr_count_q == WR_LAST) full_q <= 1'b1;
         end
      end
   end

   // Sample RAM write port.
   // NOTE: the RAM has no reset so it maps onto block RAM; only its
   // registered read output is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_count_q[AW-1:0]] <= s_axis.tdata;
   end

   // Registered read-back; a same-cycle write to rd_addr returns old data.
   always_ff @(posedge clk) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= mem[rd_addr];
   end

   assign s_axis.tready    = tready_q;
   assign capturing        = (state_q == S_CAPTURE);
   assign full             = full_q;
   assign wr_count         = wr_count_q;
   assign rd_data          = rd_data_q;
   assign tlast_missing    = missing_q;
   assign tlast_unexpected = unexpected_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture. The source sends a counter
// (tdata = beat index) with tlast every FRAME_LEN beats, so every expected
// RAM word is a known beat index.
module tb_axis_frame_capture;

   localparam int WIDTH     = 16;
   localparam int DEPTH     = 64;
   localparam int FRAME_LEN = 2048;
   localparam int SKIP_WID  = 8;
   localparam int ERR_WID   = 16;
   localparam int AW        = $clog2(DEPTH);
   localparam int CW        = $clog2(DEPTH+1);

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic                arm   = 1'b0;
   logic                align = 1'b0;
   logic [SKIP_WID-1:0] skip_frames = '0;
   logic                capturing;
   logic                full;
   logic [CW-1:0]       wr_count;
   logic [AW-1:0]       rd_addr = '0;
   logic [2*WIDTH-1:0]  rd_data;
   logic [ERR_WID-1:0]  tlast_missing;
   logic [ERR_WID-1:0]  tlast_unexpected;

   axis_frame_capture_if #(.WIDTH(WIDTH)) s_if ();

   axis_frame_capture #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN),
      .SKIP_WID(SKIP_WID), .ERR_WID(ERR_WID)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .arm(arm),
      .align(align),
      .skip_frames(skip_frames),
      .s_axis(s_if),
      .capturing(capturing),
      .full(full),
      .wr_count(wr_count),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .tlast_missing(tlast_missing),
      .tlast_unexpected(tlast_unexpected)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int n         = 0;   // index of the next beat = its tdata
   int src_pos   = 0;   // source's own frame position
   bit inj_early = 1'b0; // put a tlast on the beat at src_pos 1000
   bit drop_last = 1'b0; // omit the tlast at src_pos FRAME_LEN-1
   int cap_beats = 0;
   int first_cap = -1;
   int arm_n     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive on the falling edge, return 1 time unit after the rising edge.
   task automatic step(input bit v, input bit a);
      bit tl;
      bit early_hit;
      bit drop_hit;
      @(negedge clk);
      early_hit = inj_early && (src_pos == 1000);
      drop_hit  = drop_last && (src_pos == FRAME_LEN-1);
      tl = (src_pos == FRAME_LEN-1);
      if (early_hit) tl = 1'b1;
      if (drop_hit)  tl = 1'b0;
      s_if.tvalid = v;
      s_if.tdata  = 32'(n);
      s_if.tlast  = v & tl;
      arm = a;
      if (v && !a && capturing) begin
         if (cap_beats == 0) first_cap = n;
         cap_beats++;
      end
      @(posedge clk);
      #1;
      if (v) begin
         if (early_hit) inj_early = 1'b0;
         if (drop_hit)  drop_last = 1'b0;
         src_pos = (tl || src_pos == FRAME_LEN-1) ? 0 : src_pos + 1;
         n++;
      end
      arm = 1'b0;
   endtask

   // Sweep the read port with beats still flowing; expect RAM[i] = base + i.
   task automatic read_all(input int base, input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         step(1'b1, 1'b0);
         check($sformatf("%s[%0d]", tag, i), rd_data, 32'(base + i));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tready"},     32'(s_if.tready), 32'd0);
      check({tag, "_capturing"},  32'(capturing), 32'd0);
      check({tag, "_full"},       32'(full), 32'd0);
      check({tag, "_wr_count"},   32'(wr_count), 32'd0);
      check({tag, "_rd_data"},    rd_data, 32'd0);
      check({tag, "_missing"},    32'(tlast_missing), 32'd0);
      check({tag, "_unexpected"}, 32'(tlast_unexpected), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;

      // Reset for 4 cycles.
      rst_n = 1'b0;
      repeat (4) step(1'b0, 1'b0);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      check("tready_after_reset", 32'(s_if.tready), 32'd1);

      // align=0, skip=0, arm together with beat 10 -> RAM = 11..74.
      align = 1'b0; skip_frames = 8'd0;
      while (n < 10) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("a_capturing_after_arm", 32'(capturing), 32'd1);
      check("a_wr_count_after_arm", 32'(wr_count), 32'd0);
      while (n < 74) step(1'b1, 1'b0);
      check("a_wr_count_63", 32'(wr_count), 32'd63);
      check("a_full_before_last", 32'(full), 32'd0);
      step(1'b1, 1'b0);
      check("a_full", 32'(full), 32'd1);
      check("a_wr_count_64", 32'(wr_count), 32'd64);
      check("a_capturing_off", 32'(capturing), 32'd0);
      check("a_missing", 32'(tlast_missing), 32'd0);
      check("a_unexpected", 32'(tlast_unexpected), 32'd0);
      read_all(11, "a_ram");
      check("a_wr_count_hold", 32'(wr_count), 32'd64);
      check("a_full_hold", 32'(full), 32'd1);

      // align=1, skip=2, armed mid-frame 0 -> capture starts at beat 6144.
      align = 1'b1; skip_frames = 8'd2;
      cap_beats = 0; first_cap = -1;
      step(1'b1, 1'b1);
      check("b_armed_not_capturing", 32'(capturing), 32'd0);
      check("b_full_cleared", 32'(full), 32'd0);
      check("b_wr_count_cleared", 32'(wr_count), 32'd0);
      for (int k = 0; k < 8000 && !full; k++) step(1'b1, 1'b0);
      check("b_full", 32'(full), 32'd1);
      check("b_first_capture", 32'(first_cap), 32'd6144);
      check("b_capture_beats", 32'(cap_beats), 32'd64);
      check("b_wr_count", 32'(wr_count), 32'd64);
      read_all(6144, "b_ram");

      // align=1, skip=0 with 50% tvalid gaps -> contiguous 8192..8255.
      align = 1'b1; skip_frames = 8'd0;
      cap_beats = 0; first_cap = -1;
      step(1'b1, 1'b1);
      for (int k = 0; k < 12000 && !full; k++) step(1'($urandom_range(0, 1)), 1'b0);
      check("c_full", 32'(full), 32'd1);
      check("c_first_capture", 32'(first_cap), 32'd8192);
      check("c_capture_beats", 32'(cap_beats), 32'd64);
      check("c_wr_count", 32'(wr_count), 32'd64);
      read_all(8192, "c_ram");

      // Early tlast at position 1000, then a dropped tlast in the next frame.
      inj_early = 1'b1;
      for (int k = 0; k < 3000 && inj_early; k++) step(1'b1, 1'b0);
      check("d_unexpected_after_early", 32'(tlast_unexpected), 32'd1);
      check("d_missing_after_early", 32'(tlast_missing), 32'd0);
      drop_last = 1'b1;
      for (int k = 0; k < 3000 && drop_last; k++) step(1'b1, 1'b0);
      check("d_missing_after_drop", 32'(tlast_missing), 32'd1);
      check("d_unexpected_after_drop", 32'(tlast_unexpected), 32'd1);
      repeat (FRAME_LEN) step(1'b1, 1'b0);
      check("d_missing_clean_frame", 32'(tlast_missing), 32'd1);
      check("d_unexpected_clean_frame", 32'(tlast_unexpected), 32'd1);

      // Re-arm while capturing at wr_count=30.
      align = 1'b0; skip_frames = 8'd0;
      arm_n = n;
      step(1'b1, 1'b1);
      repeat (30) step(1'b1, 1'b0);
      check("e_wr_count_30", 32'(wr_count), 32'd30);
      check("e_capturing", 32'(capturing), 32'd1);
      step(1'b1, 1'b1);
      check("e_rearm_wr_count", 32'(wr_count), 32'd0);
      check("e_rearm_full", 32'(full), 32'd0);
      check("e_rearm_capturing", 32'(capturing), 32'd1);
      repeat (DEPTH) step(1'b1, 1'b0);
      check("e_full", 32'(full), 32'd1);
      check("e_wr_count", 32'(wr_count), 32'd64);
      read_all(arm_n + 32, "e_ram");

      // Reset in the middle of a capture.
      step(1'b1, 1'b1);
      repeat (10) step(1'b1, 1'b0);
      check("f_wr_count_10", 32'(wr_count), 32'd10);
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      check_reset_outputs("f_reset");
      rst_n = 1'b1;
      src_pos = 0;
      step(1'b0, 1'b0);
      check("f_tready", 32'(s_if.tready), 32'd1);
      repeat (5) step(1'b1, 1'b0);
      check("f_idle_not_capturing", 32'(capturing), 32'd0);
      check("f_idle_wr_count", 32'(wr_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
